// File: rtl/mont_const_unit.sv
// mont_const_unit
// Computes the Montgomery constant Const = 2^EXP mod M by repeated doubling.
// Each CALC cycle doubles the remainder r. If the doubled value is at least
// the latched modulus, the modulus is subtracted once.
// A start/done handshake frames each run. A clock enable freezes every register.
//
// Optional feature macro: MONT_CONST_ODD_CHECK_EN
//   defined   : an accepted start with an even modulus or M < 3 is rejected.
//               err and done are raised in the next cycle and CALC is never entered.
//   undefined : no check is made and err stays low. Every start runs EXP iterations.
module mont_const_unit #(
    parameter int WIDTH = 8,
    parameter int EXP   = 2 * (WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] Const,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // The counter must hold values up to EXP.
    // EXP-1 is the index of the final doubling.
    localparam int              CNT_W    = (EXP < 2) ? 1 : $clog2(EXP + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXP - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;          // modulus latched at start
    logic [WIDTH:0]   r_q, r_d;          // running remainder, always < m_q (or 0)
    logic [CNT_W-1:0] cnt_q, cnt_d;      // completed doublings in this run
    logic [WIDTH-1:0] const_q, const_d;  // published result
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   r_dbl;             // 2*r, cannot overflow since r < m_q < 2^WIDTH
    logic [WIDTH:0]   r_red;             // 2*r reduced once modulo m_q
    logic             mod_bad;           // start request carries an unusable modulus
    logic [WIDTH:0]   r_init;            // seed for r: 1, or 0 when M <= 1

    // One doubling step with a single conditional subtraction
    always_comb begin
        r_dbl = r_q << 1;
        if (r_dbl >= {1'b0, m_q}) begin
            r_red = r_dbl - {1'b0, m_q};
        end else begin
            r_red = r_dbl;
        end
    end

    // Modulus qualification and initial remainder for an incoming request
    always_comb begin
        r_init = {{WIDTH{1'b0}}, (M > WIDTH'(1))};
`ifdef MONT_CONST_ODD_CHECK_EN
        mod_bad = (M[0] == 1'b0) || (M < WIDTH'(3));
`else
        mod_bad = 1'b0;
`endif
    end

    // Next-state and datapath update. Nothing moves while en is low.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        const_d = const_q;
        done_d  = done_q;
        err_d   = err_q;

        if (en) begin
            // done lasts exactly one enabled cycle
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        m_d   = M;
                        r_d   = r_init;
                        cnt_d = '0;
                        err_d = mod_bad;
                        if (mod_bad) begin
                            // Rejected request: report it immediately and stay idle
                            done_d  = 1'b1;
                            const_d = '0;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_d   = r_red;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        // Publish the value produced by this final doubling
                        const_d = r_red[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            const_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            const_q <= const_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // busy is decoded directly from the state. The other outputs come straight from flops.
    always_comb begin
        busy  = (state_q == S_CALC);
        Const = const_q;
        done  = done_q;
        err   = err_q;
    end

endmodule

// File: tb/tb_mont_const_unit.sv
// Directed testbench for mont_const_unit with WIDTH=8 and EXP=20.
// Each test task drives its own scenario and makes its own comparisons.
module tb_mont_const_unit;

    logic       clk;
    logic       rstb;
    logic       en;
    logic       start;
    logic [7:0] M;
    logic [7:0] Const;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    mont_const_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .en    (en),
        .start (start),
        .M     (M),
        .Const (Const),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start in the current cycle S. Returns in cycle S+1.
    task automatic start_run(input logic [7:0] m);
        M     = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Count cycles from the current one (index 1) until done is seen.
    // Also count the busy cycles seen before done. lat=-1 means the wait timed out.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        rstb  = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        M     = 8'd0;
        #3;
        checks++; if ({Const, busy, done, err} !== 11'd0) begin errors++;
            $display("FAIL reset_outputs: got Const=%0d busy=%b done=%b err=%b, need all 0", Const, busy, done, err); end
        step(); step();
        rstb = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", busy, done); end
        $display("test_reset done");
    endtask

    task automatic test_nominal();
        int lat, bc;
        start_run(8'd187);
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL nom_busy_s1: got %b need 1", busy); end
        wait_done(lat, bc);
        checks++; if (lat !== 21) begin errors++;
            $display("FAIL nom_latency: got %0d need 21", lat); end
        checks++; if (bc !== 20) begin errors++;
            $display("FAIL nom_busy_cycles: got %0d need 20", bc); end
        checks++; if (Const !== 8'd67 || err !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL nom_result: got Const=%0d err=%b busy=%b need 67 0 0", Const, err, busy); end
        step();
        checks++; if (done !== 1'b0 || Const !== 8'd67) begin errors++;
            $display("FAIL nom_pulse_end: got done=%b Const=%0d need 0 67", done, Const); end
        $display("txn nominal M=187 lat=%0d Const=%0d", lat, Const);
    endtask

    task automatic test_back_to_back();
        logic [7:0] mods [3];
        logic [7:0] exps [3];
        int lat, bc;
        mods[0] = 8'd255; exps[0] = 8'd16;
        mods[1] = 8'd251; exps[1] = 8'd149;
        mods[2] = 8'd3;   exps[2] = 8'd1;
        // Start the first run on its own; start each later run in the previous run's done cycle
        for (int i = 0; i < 3; i++) begin
            start_run(mods[i]);
            if (i > 0) begin
                checks++; if (Const !== exps[i-1] || busy !== 1'b1) begin errors++;
                    $display("FAIL b2b_hold_%0d: got Const=%0d busy=%b need %0d 1", i, Const, busy, exps[i-1]); end
            end
            wait_done(lat, bc);
            checks++; if (lat !== 21) begin errors++;
                $display("FAIL b2b_latency_%0d: got %0d need 21", i, lat); end
            checks++; if (Const !== exps[i]) begin errors++;
                $display("FAIL b2b_const_%0d: got %0d need %0d", i, Const, exps[i]); end
            $display("txn b2b M=%0d lat=%0d Const=%0d", mods[i], lat, Const);
        end
        step();
    endtask

    task automatic test_stall();
        int lat, bc;
        start_run(8'd187);
        for (int i = 0; i < 5; i++) step();
        // Cycle S+6: 5 doublings are done, so r = 32 and cnt = 5
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (dut.cnt_q !== 5'd5 || dut.r_q !== 9'd32 || busy !== 1'b1) begin errors++;
            $display("FAIL stall_frozen: got cnt=%0d r=%0d busy=%b need 5 32 1", dut.cnt_q, dut.r_q, busy); end
        en = 1'b1;
        wait_done(lat, bc);
        checks++; if (10 + lat !== 26) begin errors++;
            $display("FAIL stall_latency: got S+%0d need S+26", 10 + lat); end
        checks++; if (Const !== 8'd67) begin errors++;
            $display("FAIL stall_const: got %0d need 67", Const); end
        // Hold done with en low; it must stay high until the next enabled edge
        en = 1'b0;
        step(); step();
        checks++; if (done !== 1'b1) begin errors++;
            $display("FAIL stall_done_hold: got %b need 1", done); end
        en = 1'b1;
        step();
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL stall_done_clear: got %b need 0", done); end
        $display("txn stall M=187 done_at=S+%0d Const=%0d", 10 + lat, Const);
    endtask

    task automatic test_ignored_inputs();
        int lat, bc, extra;
        start_run(8'd187);
        step(); step(); step();
        M     = 8'd251;
        start = 1'b1;
        step(); step();
        start = 1'b0;
        wait_done(lat, bc);
        checks++; if (5 + lat !== 21) begin errors++;
            $display("FAIL ign_latency: got S+%0d need S+21", 5 + lat); end
        checks++; if (Const !== 8'd67) begin errors++;
            $display("FAIL ign_const: got %0d need 67", Const); end
        extra = 0;
        step();
        for (int i = 0; i < 30; i++) begin
            if (done || busy) extra++;
            step();
        end
        checks++; if (extra !== 0) begin errors++;
            $display("FAIL ign_second_run: got %0d active cycles need 0", extra); end
        $display("txn ignored M=187 (M=251 during busy) Const=%0d", Const);
    endtask

    task automatic test_reset_midop();
        int lat, bc;
        start_run(8'd251);
        for (int i = 0; i < 9; i++) step();
        #2 rstb = 1'b0;
        #1;
        checks++; if (Const !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL midrst_outputs: got Const=%0d busy=%b done=%b need 0 0 0", Const, busy, done); end
        checks++; if (dut.cnt_q !== 5'd0 || dut.r_q !== 9'd0 || dut.m_q !== 8'd0) begin errors++;
            $display("FAIL midrst_internal: got cnt=%0d r=%0d m=%0d need 0 0 0", dut.cnt_q, dut.r_q, dut.m_q); end
        step(); step();
        rstb = 1'b1;
        step();
        start_run(8'd251);
        wait_done(lat, bc);
        checks++; if (lat !== 21 || Const !== 8'd149) begin errors++;
            $display("FAIL midrst_rerun: got lat=%0d Const=%0d need 21 149", lat, Const); end
        $display("txn reset_midop rerun M=251 Const=%0d", Const);
        step();
    endtask

    task automatic test_modulus_check();
        int lat, bc;
`ifdef MONT_CONST_ODD_CHECK_EN
        int busy_seen;
        start_run(8'd186);
        checks++; if (done !== 1'b1 || err !== 1'b1 || Const !== 8'd0 || busy !== 1'b0) begin errors++;
            $display("FAIL chk_reject: got done=%b err=%b Const=%0d busy=%b need 1 1 0 0", done, err, Const, busy); end
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy) busy_seen++;
        end
        checks++; if (busy_seen !== 0 || err !== 1'b1) begin errors++;
            $display("FAIL chk_idle: got busy_cycles=%0d err=%b need 0 1", busy_seen, err); end
        start_run(8'd187);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL chk_clear: got err=%b busy=%b need 0 1", err, busy); end
        wait_done(lat, bc);
        checks++; if (lat !== 21 || Const !== 8'd67 || err !== 1'b0) begin errors++;
            $display("FAIL chk_after: got lat=%0d Const=%0d err=%b need 21 67 0", lat, Const, err); end
        $display("txn modcheck M=186 rejected, M=187 Const=%0d", Const);
`else
        start_run(8'd1);
        wait_done(lat, bc);
        checks++; if (lat !== 21 || Const !== 8'd0 || err !== 1'b0) begin errors++;
            $display("FAIL nochk_m1: got lat=%0d Const=%0d err=%b need 21 0 0", lat, Const, err); end
        $display("txn nocheck M=1 lat=%0d Const=%0d", lat, Const);
        start_run(8'd187);
        wait_done(lat, bc);
        start_run(8'd0);
        wait_done(lat, bc);
        checks++; if (lat !== 21 || Const !== 8'd0 || err !== 1'b0) begin errors++;
            $display("FAIL nochk_m0: got lat=%0d Const=%0d err=%b need 21 0 0", lat, Const, err); end
        $display("txn nocheck M=0 lat=%0d Const=%0d", lat, Const);
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_stall();
        test_ignored_inputs();
        test_reset_midop();
        test_modulus_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mont_const_unit.md
# mont_const_unit

Sequential pre-computation stage that sits directly upstream of the RSA exponentiation unit. It derives the Montgomery constant Const = 2^EXP mod M, with EXP = 2·(WIDTH+2), from the modulus M. That constant drives the Const input of the exponentiation unit. The block uses an iterative shift-and-conditional-subtract datapath, one doubling per clock, and has a start/done handshake.

## Interface
- WIDTH, 8: operand width in bits; matches the exponentiation unit's WIDTH.
- EXP, 2*(WIDTH+2): power of two to reduce; R² for the exponentiation unit's (WIDTH+2)-bit Montgomery multipliers. Must be ≥ 1.

- clk  in  1  system clock, rising edge.
- rstb  in  1  reset, asynchronous, active-low.
- en  in  1  clock enable; when low, all registers hold.
- start  in  1  request; sampled only in IDLE with en=1.
- M  in  WIDTH  modulus; latched on accepted start.
- Const  out  WIDTH  result; registered and held until the next accepted start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when Const/err are updated.
- err  out  1  invalid modulus flag (see Configuration); held until the next accepted start.

## Operation
- States: IDLE, CALC.
- Internal registers:
  - m_q: WIDTH bits.
  - r: WIDTH+1 bits.
  - cnt: ceil(log2(EXP+1)) bits.
- IDLE, start=1, en=1 (accepted start):
  - m_q←M; r←(M>1)?1:0; cnt←0; err←0.
  - State→CALC, unless the invalid-modulus check fires (Configuration).
- CALC, each enabled cycle:
  - t=2·r, computed at WIDTH+1 bits. This cannot overflow because r<m_q.
  - r←(t≥m_q)?t−m_q:t.
  - cnt←cnt+1.
- Completion: on the cycle where cnt==EXP−1:
  - Const←r_next[WIDTH-1:0]; done←1; state→IDLE.
- Invariant: r<m_q at all times, or r=0 when m_q≤1. Consequences: M=1 → Const=0; M=0 → Const=0.
- M changes while busy are ignored; the latched m_q is used.
- start while busy is ignored, not queued.
- start high in the cycle done is high is accepted, because the FSM is already in IDLE. Back-to-back runs are legal.
- en low: state, counter, r, Const, busy and err freeze.
- done pulse: done is cleared on the next enabled cycle, so the pulse lasts one enabled cycle.
- Reset, any time including mid-CALC:
  - Outputs: Const=0, busy=0, done=0, err=0.
  - Internal: state=IDLE, r=0, cnt=0, m_q=0.

## Timing
- Start accepted at edge E0 (end of cycle S).
- busy=1 in cycles S+1 … S+EXP.
- done=1 and Const valid in cycle S+EXP+1. Latency is EXP+1 cycles from start to done, counted in enabled cycles.
- busy is combinationally (state==CALC).
- done and Const are registered outputs.
- Invalid modulus (check enabled): done=1 and err=1 in cycle S+1; busy never asserts.
- Throughput: one result per EXP+1 cycles.

## Configuration
- Macro: MONT_CONST_ODD_CHECK_EN.
- Defined:
  - An accepted start with M even or M<3 does not enter CALC.
  - At E0: err←1, done←1, Const←0; state stays IDLE.
- Undefined:
  - No check; err is tied to 0.
  - Every accepted start runs the full EXP iterations, including even M, M=0 and M=1, per the invariant above.

## Test plan
All scenarios use WIDTH=8, EXP=20.
- Nominal: reset, then M=187 with a one-cycle start. Required: busy for 20 cycles; done pulse at S+21; Const=67; err=0.
- Corner moduli, back-to-back, with start raised in the done cycle of each previous run:
  - M=255 → Const=16.
  - M=251 → Const=149.
  - M=3 → Const=1.
  - Each result must arrive exactly 21 cycles after its start.
- Stall: M=187; hold en=0 for 5 cycles mid-CALC. Required: busy/r/cnt frozen; done at S+26; Const=67.
- Ignored inputs: M=187, then start=1 and M=251 during busy. Required: single done; Const=67; no second run.
- Reset mid-op: M=251, deassert rstb at cycle S+10. Required: Const=0, busy=0, done=0 immediately (asynchronous). A new start after release gives Const=149.
- Modulus check:
  - With MONT_CONST_ODD_CHECK_EN, M=186: done and err at S+1, Const=0, busy never high. A subsequent M=187 clears err and gives Const=67.
  - Without the macro, M=1: Const=0, err=0, done at S+21.
